riscv_decode: RTL and testbench



---
 rtl/riscv_defs_pkg.sv | 34 +++
 rtl/riscv_decode_fifo.sv | 59 +++++
 rtl/riscv_decode.sv | 133 +++++++++++++
 tb/tb_riscv_decode.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs_pkg.sv
// Shared RISC-V decode definitions: base opcodes, the fetch-fault marker word and the
// packed functional-unit class vector handed to issue.
package riscv_defs_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Fetch substitutes this word on a bus/page fault; its opcode field looks like SYSTEM,
    // so it must be matched as a whole word before any opcode classification.
    localparam logic [31:0] INST_FAULT = 32'hDEAD_0073;

    typedef struct packed {
        logic exec;
        logic lsu;
        logic branch;
        logic mul;
        logic div;
        logic csr;
        logic rd_valid;
        logic invalid;
    } dec_class_t;

endpackage

// File: rtl/riscv_decode_fifo.sv
// Instruction buffer: write-to-head latency 1 cycle, no bypass; full/empty come from registered
// count only, flush clears pointers and count next cycle and overrides push and pop.
module riscv_decode_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 1,
    parameter int WIDTH  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] rd_dat,
    output logic             not_full,
    output logic             not_empty
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count;
    logic              push_ok;
    logic              pop_ok;

    assign not_full  = (count != FULL_COUNT);
    assign not_empty = (count != '0);
    assign push_ok   = push && not_full && !flush;
    assign pop_ok    = pop && not_empty && !flush;
    assign rd_dat    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/riscv_decode.sv
// Decode stage: buffered head classified combinationally, 1-cycle fetch-to-head latency; fetch
// accept is registered (FIFO not full). M-extension decode enabled by RISCV_DECODE_MULDIV_EN.
module riscv_decode
    import riscv_defs_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_in_valid_i,
    input  logic [31:0] fetch_in_instr_i,
    input  logic [31:0] fetch_in_pc_i,
    output logic        fetch_in_accept_o,
    input  logic        branch_request_i,
    output logic        fetch_out_valid_o,
    output logic [31:0] fetch_out_instr_o,
    output logic [31:0] fetch_out_pc_o,
    input  logic        fetch_out_accept_i,
    output logic        fetch_out_exec_o,
    output logic        fetch_out_lsu_o,
    output logic        fetch_out_branch_o,
    output logic        fetch_out_mul_o,
    output logic        fetch_out_div_o,
    output logic        fetch_out_csr_o,
    output logic        fetch_out_rd_valid_o,
    output logic        fetch_out_invalid_o
);

    logic        fifo_not_full;
    logic        fifo_not_empty;
    logic        push;
    logic        pop;
    logic [63:0] head_dat;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        rd_wr;
    dec_class_t  cls;

    assign fetch_in_accept_o = fifo_not_full;
    assign fetch_out_valid_o = fifo_not_empty && !branch_request_i;
    assign push = fetch_in_valid_i && fetch_in_accept_o && !branch_request_i;
    assign pop  = fetch_out_valid_o && fetch_out_accept_i;

    riscv_decode_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (64)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .pop       (pop),
        .flush     (branch_request_i),
        .wr_dat    ({fetch_in_pc_i, fetch_in_instr_i}),
        .rd_dat    (head_dat),
        .not_full  (fifo_not_full),
        .not_empty (fifo_not_empty)
    );

    assign fetch_out_pc_o    = head_dat[63:32];
    assign fetch_out_instr_o = head_dat[31:0];

    assign opcode = fetch_out_instr_o[6:0];
    assign rd     = fetch_out_instr_o[11:7];
    assign funct3 = fetch_out_instr_o[14:12];
    assign funct7 = fetch_out_instr_o[31:25];

    always_comb begin
        cls   = '0;
        rd_wr = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == FUNCT7_MULDIV) begin
`ifdef RISCV_DECODE_MULDIV_EN
                    cls.mul = !funct3[2];
                    cls.div = funct3[2];
                    rd_wr   = 1'b1;
`else
                    cls.invalid = 1'b1;
`endif
                end else begin
                    cls.exec = 1'b1;
                    rd_wr    = 1'b1;
                end
            end
            OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                cls.exec = 1'b1;
                rd_wr    = 1'b1;
            end
            OPC_LOAD: begin
                cls.lsu = 1'b1;
                rd_wr   = 1'b1;
            end
            OPC_STORE:  cls.lsu = 1'b1;
            OPC_BRANCH: cls.branch = 1'b1;
            OPC_JAL, OPC_JALR: begin
                cls.branch = 1'b1;
                rd_wr      = 1'b1;
            end
            // ECALL/EBREAK/xRET share funct3=0 and write nothing; CSR accesses return the old value.
            OPC_SYSTEM: begin
                cls.csr = 1'b1;
                rd_wr   = (funct3 != 3'd0);
            end
            OPC_FENCE:  cls.csr = 1'b1;
            default:    cls.invalid = 1'b1;
        endcase

        if (fetch_out_instr_o == INST_FAULT) begin
            cls         = '0;
            rd_wr       = 1'b0;
            cls.invalid = 1'b1;
        end

        cls.rd_valid = rd_wr && (rd != 5'd0);

        if (!fetch_out_valid_o) cls = '0;
    end

    assign fetch_out_exec_o     = cls.exec;
    assign fetch_out_lsu_o      = cls.lsu;
    assign fetch_out_branch_o   = cls.branch;
    assign fetch_out_mul_o      = cls.mul;
    assign fetch_out_div_o      = cls.div;
    assign fetch_out_csr_o      = cls.csr;
    assign fetch_out_rd_valid_o = cls.rd_valid;
    assign fetch_out_invalid_o  = cls.invalid;

endmodule

// File: tb/tb_riscv_decode.sv
// Directed bench for riscv_decode: FIFO ordering, back-pressure, flush, class decode and streaming.
module tb_riscv_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_accept;
    logic        branch_req;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_accept;
    logic        exec_f, lsu_f, branch_f, mul_f, div_f, csr_f, rdv_f, inv_f;
    logic [7:0]  flags;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] FAULT_WORD = 32'hDEAD_0073;

    always #5 clk = ~clk;

    assign flags = {exec_f, lsu_f, branch_f, mul_f, div_f, csr_f, rdv_f, inv_f};

    riscv_decode dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .fetch_in_valid_i     (in_valid),
        .fetch_in_instr_i     (in_instr),
        .fetch_in_pc_i        (in_pc),
        .fetch_in_accept_o    (in_accept),
        .branch_request_i     (branch_req),
        .fetch_out_valid_o    (out_valid),
        .fetch_out_instr_o    (out_instr),
        .fetch_out_pc_o       (out_pc),
        .fetch_out_accept_i   (out_accept),
        .fetch_out_exec_o     (exec_f),
        .fetch_out_lsu_o      (lsu_f),
        .fetch_out_branch_o   (branch_f),
        .fetch_out_mul_o      (mul_f),
        .fetch_out_div_o      (div_f),
        .fetch_out_csr_o      (csr_f),
        .fetch_out_rd_valid_o (rdv_f),
        .fetch_out_invalid_o  (inv_f)
    );

    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_accept = 1'b1;
        @(posedge clk); #1;
        out_accept = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL reset_accept got %b want 1", in_accept); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (flags !== 8'h00) begin errors++; $display("FAIL reset_flags got %b want 00000000", flags); end
    endtask

    task automatic test_addi();
        out_accept = 1'b0;
        push_one(32'h0050_0093, 32'h8000_0000);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
        checks++; if (flags !== 8'b1000_0010) begin errors++; $display("FAIL addi_flags got %b want 10000010", flags); end
        checks++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL addi_pc got %h want 80000000", out_pc); end
        checks++; if (out_instr !== 32'h0050_0093) begin errors++; $display("FAIL addi_instr got %h want 00500093", out_instr); end
        pop_one();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drained got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_accept = 1'b0;
        push_one(32'h0010_0113, 32'h0000_1000);
        push_one(32'h0020_0193, 32'h0000_1004);
        @(negedge clk);
        checks++; if (in_accept !== 1'b0) begin errors++; $display("FAIL bp_full_accept got %b want 0", in_accept); end
        checks++; if (out_instr !== 32'h0010_0113) begin errors++; $display("FAIL bp_head_a got %h want 00100113", out_instr); end
        in_valid = 1'b1;
        in_instr = 32'h0030_0213;
        in_pc    = 32'h0000_1008;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (in_accept !== 1'b0) begin errors++; $display("FAIL bp_held_accept got %b want 0", in_accept); end
        checks++; if (out_instr !== 32'h0010_0113) begin errors++; $display("FAIL bp_held_head got %h want 00100113", out_instr); end
        out_accept = 1'b1;
        @(posedge clk); #1;
        out_accept = 1'b0;
        @(negedge clk);
        checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL bp_reaccept got %b want 1", in_accept); end
        checks++; if (out_instr !== 32'h0020_0193) begin errors++; $display("FAIL bp_head_b got %h want 00200193", out_instr); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (in_accept !== 1'b0) begin errors++; $display("FAIL bp_refull got %b want 0", in_accept); end
        pop_one();
        @(negedge clk);
        checks++; if (out_instr !== 32'h0030_0213) begin errors++; $display("FAIL bp_head_c got %h want 00300213", out_instr); end
        checks++; if (out_pc !== 32'h0000_1008) begin errors++; $display("FAIL bp_pc_c got %h want 00001008", out_pc); end
        pop_one();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_accept = 1'b0;
        push_one(32'h0040_0293, 32'h0000_2000);
        push_one(32'h0050_0313, 32'h0000_2004);
        @(negedge clk);
        checks++; if (in_accept !== 1'b0) begin errors++; $display("FAIL flush_prefull got %b want 0", in_accept); end
        branch_req = 1'b1;
        in_valid   = 1'b1;
        in_instr   = 32'h0060_0393;
        in_pc      = 32'h0000_2008;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_same_valid got %b want 0", out_valid); end
        checks++; if (flags !== 8'h00) begin errors++; $display("FAIL flush_same_flags got %b want 00000000", flags); end
        @(posedge clk); #1;
        branch_req = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL flush_accept got %b want 1", in_accept); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b want 0", out_valid); end
        push_one(32'h0070_0413, 32'h0000_3000);
        @(negedge clk);
        checks++; if (out_instr !== 32'h0070_0413) begin errors++; $display("FAIL flush_next_head got %h want 00700413", out_instr); end
        checks++; if (out_pc !== 32'h0000_3000) begin errors++; $display("FAIL flush_next_pc got %h want 00003000", out_pc); end
        pop_one();
    endtask

    task automatic test_muldiv();
        logic [7:0] exp_mul;
        logic [7:0] exp_div;
`ifdef RISCV_DECODE_MULDIV_EN
        exp_mul = 8'b0001_0000;
        exp_div = 8'b0000_1010;
`else
        exp_mul = 8'b0000_0001;
        exp_div = 8'b0000_0001;
`endif
        out_accept = 1'b0;
        push_one(32'h0220_8033, 32'h0000_4000);
        @(negedge clk);
        checks++; if (flags !== exp_mul) begin errors++; $display("FAIL mul_flags got %b want %b", flags, exp_mul); end
        pop_one();
        push_one(32'h0220_C1B3, 32'h0000_4004);
        @(negedge clk);
        checks++; if (flags !== exp_div) begin errors++; $display("FAIL div_flags got %b want %b", flags, exp_div); end
        pop_one();
    endtask

    task automatic test_classes();
        logic [31:0] vec_instr [12];
        logic [7:0]  vec_flags [12];
        vec_instr[0]  = 32'h0000_A283; vec_flags[0]  = 8'b0100_0010; // LW x5
        vec_instr[1]  = 32'h0050_A023; vec_flags[1]  = 8'b0100_0000; // SW
        vec_instr[2]  = 32'h0000_0063; vec_flags[2]  = 8'b0010_0000; // BEQ
        vec_instr[3]  = 32'h0000_00EF; vec_flags[3]  = 8'b0010_0010; // JAL x1
        vec_instr[4]  = 32'h0000_8067; vec_flags[4]  = 8'b0010_0000; // JALR x0
        vec_instr[5]  = 32'h3000_22F3; vec_flags[5]  = 8'b0000_0110; // CSRRS x5
        vec_instr[6]  = 32'h0000_0073; vec_flags[6]  = 8'b0000_0100; // ECALL
        vec_instr[7]  = 32'h0FF0_000F; vec_flags[7]  = 8'b0000_0100; // FENCE
        vec_instr[8]  = 32'h1234_53B7; vec_flags[8]  = 8'b1000_0010; // LUI x7
        vec_instr[9]  = 32'h0000_1017; vec_flags[9]  = 8'b1000_0000; // AUIPC x0
        vec_instr[10] = FAULT_WORD;    vec_flags[10] = 8'b0000_0001;
        vec_instr[11] = 32'hFFFF_FFFF; vec_flags[11] = 8'b0000_0001;
        out_accept = 1'b0;
        for (int i = 0; i < 12; i++) begin
            push_one(vec_instr[i], 32'h0000_5000 + 32'(i * 4));
            @(negedge clk);
            checks++;
            if (flags !== vec_flags[i] || out_valid !== 1'b1 || out_instr !== vec_instr[i]) begin
                errors++;
                $display("FAIL class_%0d instr %h got flags %b valid %b want flags %b valid 1",
                         i, out_instr, flags, out_valid, vec_flags[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_reset_mid();
        out_accept = 1'b0;
        push_one(32'h0080_0493, 32'h0000_6000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL midrst_accept got %b want 1", in_accept); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_after got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        in_valid   = 1'b1;
        out_accept = 1'b1;
        in_instr   = 32'h0000_0093;
        in_pc      = 32'h0000_7000;
        @(posedge clk); #1;
        for (int k = 1; k <= 10; k++) begin
            in_instr = 32'h0000_0093 | (32'(k) << 20);
            in_pc    = 32'h0000_7000 + 32'(k * 4);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_accept !== 1'b1 ||
                out_instr !== (32'h0000_0093 | (32'(k - 1) << 20))) begin
                errors++;
                $display("FAIL stream_%0d got valid %b accept %b instr %h want 1 1 %h",
                         k, out_valid, in_accept, out_instr, 32'h0000_0093 | (32'(k - 1) << 20));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_instr !== 32'h00A0_0093) begin errors++; $display("FAIL stream_last got %h want 00a00093", out_instr); end
        @(posedge clk); #1;
        out_accept = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got %b want 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_pc      = '0;
        branch_req = 1'b0;
        out_accept = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_addi();
        test_backpressure();
        test_flush();
        test_muldiv();
        test_classes();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
